// File: rtl/tq_pingpong_ram.sv
// Two-bank ping-pong buffer between the transform/quant producer and its consumer.
// Bank ownership moves through wr_done/rd_done; per-lane write masks; sticky misuse flags.
module tq_pingpong_ram #(
    parameter int WIDTH = 128,
    parameter int AW    = 5,
    parameter int LANES = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [LANES-1:0] wmask_i,
    input  logic             wr_done_i,
    output logic             wr_ready_o,
    output logic             wr_bank_o,
    input  logic             rd_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             rdata_vld_o,
    input  logic             rd_done_i,
    output logic             rd_avail_o,
    output logic             rd_bank_o,
    output logic [1:0]       fill_cnt_o,
    output logic             err_ovf_o,
    output logic             err_udf_o
);
    localparam int DEPTH = 2 ** AW;
    localparam int LW    = WIDTH / LANES;

    // Handshakes: a strobe takes effect only at a rising edge where it is high
    // and the matching status (wr_ready / rd_avail) is high; otherwise it is
    // dropped and the corresponding sticky error flag is set.

    logic [WIDTH-1:0] mem_q [2*DEPTH];

    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_udf_q, err_udf_d;
    logic [WIDTH-1:0] rdata_q;
    logic             rdata_vld_q;

    logic             wr_ready, rd_avail;
    logic             wr_acc, wd_acc, rd_acc, rdn_acc;
    logic [AW:0]      widx, ridx;

    assign wr_ready = (cnt_q != 2'd2);
    assign rd_avail = (cnt_q != 2'd0);
    assign wr_acc   = we_i && wr_ready;
    assign wd_acc   = wr_done_i && wr_ready;
    assign rd_acc   = rd_i && rd_avail;
    assign rdn_acc  = rd_done_i && rd_avail;
    assign widx     = {wr_ptr_q, waddr_i};
    assign ridx     = {rd_ptr_q, raddr_i};

    always_comb begin
        wr_ptr_d  = wr_ptr_q ^ wd_acc;
        rd_ptr_d  = rd_ptr_q ^ rdn_acc;
        cnt_d     = cnt_q;
        case ({wd_acc, rdn_acc})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        err_ovf_d = err_ovf_q | ((we_i | wr_done_i) & ~wr_ready);
        err_udf_d = err_udf_q | ((rd_i | rd_done_i) & ~rd_avail);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            err_ovf_q   <= 1'b0;
            err_udf_q   <= 1'b0;
            rdata_q     <= '0;
            rdata_vld_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            err_ovf_q   <= err_ovf_d;
            err_udf_q   <= err_udf_d;
            rdata_vld_q <= rd_acc;
            // Read uses the bank owned before any same-cycle rd_done swap.
            if (rd_acc) rdata_q <= mem_q[ridx];
        end
    end

    // Storage has no reset; the owner always rewrites a bank before handing it over.
    always_ff @(posedge clk_i) begin
        if (wr_acc && !rst_i) begin
            for (int l = 0; l < LANES; l++) begin
                if (wmask_i[l]) mem_q[widx][l*LW +: LW] <= wdata_i[l*LW +: LW];
            end
        end
    end

    assign wr_ready_o  = wr_ready;
    assign rd_avail_o  = rd_avail;
    assign wr_bank_o   = wr_ptr_q;
    assign rd_bank_o   = rd_ptr_q;
    assign fill_cnt_o  = cnt_q;
    assign err_ovf_o   = err_ovf_q;
    assign err_udf_o   = err_udf_q;
    assign rdata_o     = rdata_q;
    assign rdata_vld_o = rdata_vld_q;

endmodule

// File: tb/tb_tq_pingpong_ram.sv
// Directed bench for tq_pingpong_ram: fill/drain, lane masks, full/empty misuse,
// simultaneous swap and mid-read reset.
module tb_tq_pingpong_ram;
  localparam int WIDTH = 128;
  localparam int AW    = 5;
  localparam int LANES = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             we, wr_done, rd, rd_done;
  logic [AW-1:0]    waddr, raddr;
  logic [WIDTH-1:0] wdata;
  logic [LANES-1:0] wmask;
  logic             wr_ready, wr_bank, rdata_vld, rd_avail, rd_bank, err_ovf, err_udf;
  logic [WIDTH-1:0] rdata;
  logic [1:0]       fill_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] upper_ones;

  tq_pingpong_ram #(.WIDTH(WIDTH), .AW(AW), .LANES(LANES)) dut (
    .clk_i(clk), .rst_i(rst),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wmask_i(wmask),
    .wr_done_i(wr_done), .wr_ready_o(wr_ready), .wr_bank_o(wr_bank),
    .rd_i(rd), .raddr_i(raddr), .rdata_o(rdata), .rdata_vld_o(rdata_vld),
    .rd_done_i(rd_done), .rd_avail_o(rd_avail), .rd_bank_o(rd_bank),
    .fill_cnt_o(fill_cnt), .err_ovf_o(err_ovf), .err_udf_o(err_udf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic exp_wr_ready, input logic exp_rd_avail,
                              input logic exp_wr_bank, input logic exp_rd_bank, input logic [1:0] exp_fill);
    check({tag, "_wr_ready"}, WIDTH'(wr_ready), WIDTH'(exp_wr_ready));
    check({tag, "_rd_avail"}, WIDTH'(rd_avail), WIDTH'(exp_rd_avail));
    check({tag, "_wr_bank"},  WIDTH'(wr_bank),  WIDTH'(exp_wr_bank));
    check({tag, "_rd_bank"},  WIDTH'(rd_bank),  WIDTH'(exp_rd_bank));
    check({tag, "_fill_cnt"}, WIDTH'(fill_cnt), WIDTH'(exp_fill));
  endtask

  initial begin
    upper_ones = {{64{1'b1}}, {64{1'b0}}};
    rst = 1'b1; we = 1'b0; wr_done = 1'b0; rd = 1'b0; rd_done = 1'b0;
    waddr = '0; raddr = '0; wdata = '0; wmask = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset values
    check_status("reset", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    check("reset_rdata", rdata, '0);
    check("reset_vld", WIDTH'(rdata_vld), '0);
    check("reset_ovf", WIDTH'(err_ovf), '0);
    check("reset_udf", WIDTH'(err_udf), '0);

    // Read while empty: ignored, sets err_udf
    rd = 1'b1; raddr = 5'd3;
    tick();
    rd = 1'b0;
    check("empty_rd_vld", WIDTH'(rdata_vld), '0);
    check("empty_rd_rdata", rdata, '0);
    check("empty_rd_udf", WIDTH'(err_udf), 1);
    check("empty_rd_fill", WIDTH'(fill_cnt), '0);

    // Fill bank 0 with k at address k
    wmask = 8'hFF;
    for (int k = 0; k < 32; k++) begin
      we = 1'b1; waddr = AW'(k); wdata = WIDTH'(k);
      tick();
    end
    we = 1'b0; wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check_status("fill0", 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);

    // Drain bank 0, one-cycle latency
    for (int k = 0; k < 32; k++) begin
      rd = 1'b1; raddr = AW'(k);
      tick();
      check($sformatf("rd0_vld_%0d", k), WIDTH'(rdata_vld), 1);
      check($sformatf("rd0_data_%0d", k), rdata, WIDTH'(k));
    end
    rd = 1'b0;
    tick();
    check("idle_vld", WIDTH'(rdata_vld), '0);
    check("idle_hold", rdata, WIDTH'(31));

    // Lane masks into bank 1, address 5; wmask=0 is a no-op
    we = 1'b1; waddr = 5'd5; wdata = '1; wmask = 8'hFF;
    tick();
    wdata = '0; wmask = 8'h0F;
    tick();
    wdata = WIDTH'(128'h1234); wmask = 8'h00;
    tick();
    we = 1'b0; wr_done = 1'b1; wmask = 8'hFF;
    tick();
    wr_done = 1'b0;
    check_status("full", 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    check("full_ovf_clear", WIDTH'(err_ovf), '0);

    // Write and wr_done while full: ignored, set err_ovf
    we = 1'b1; waddr = 5'd0; wdata = WIDTH'(128'hABC); wr_done = 1'b1;
    tick();
    we = 1'b0; wr_done = 1'b0;
    check("ovf_flag", WIDTH'(err_ovf), 1);
    check_status("ovf", 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);

    // Return bank 0
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check_status("ret0", 1'b1, 1'b1, 1'b0, 1'b1, 2'd1);

    rd = 1'b1; raddr = 5'd5;
    tick();
    rd = 1'b0;
    check("mask_vld", WIDTH'(rdata_vld), 1);
    check("mask_data", rdata, upper_ones);

    // Bank 0 address 3 gets CAFE in the same cycle as both swaps; read of bank 1 uses the old bank
    we = 1'b1; waddr = 5'd3; wdata = WIDTH'(128'hCAFE);
    wr_done = 1'b1; rd_done = 1'b1; rd = 1'b1; raddr = 5'd5;
    tick();
    we = 1'b0; wr_done = 1'b0; rd_done = 1'b0; rd = 1'b0;
    check_status("swap", 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
    check("swap_vld", WIDTH'(rdata_vld), 1);
    check("swap_data", rdata, upper_ones);

    rd = 1'b1; raddr = 5'd0;
    tick();
    check("ovf_ignored_data", rdata, '0);
    raddr = 5'd3;
    tick();
    check("we_with_done_data", rdata, WIDTH'(128'hCAFE));
    raddr = 5'd31;
    tick();
    rd = 1'b0;
    check("tail_data", rdata, WIDTH'(31));
    check("udf_sticky", WIDTH'(err_udf), 1);
    check("ovf_sticky", WIDTH'(err_ovf), 1);

    // Reset right after an accepted read drops it
    rd = 1'b1; raddr = 5'd1;
    tick();
    rd = 1'b0; rst = 1'b1;
    check("pre_rst_vld", WIDTH'(rdata_vld), 1);
    check("pre_rst_data", rdata, WIDTH'(1));
    tick();
    rst = 1'b0;
    check("rst_vld", WIDTH'(rdata_vld), '0);
    check("rst_rdata", rdata, '0);
    check_status("rst", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    check("rst_ovf", WIDTH'(err_ovf), '0);
    check("rst_udf", WIDTH'(err_udf), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/tq_pingpong_ram.md
# tq_pingpong_ram

Parametrised ping-pong two-port buffer between the transform/quant datapath and its consumer (reconstruction or CAVLC). It holds two banks of DEPTH x WIDTH words. The producer fills one bank while the consumer drains the other, and bank ownership passes through done/ready handshakes. It adds per-lane write masking, a registered read-valid flag and sticky protocol-error flags over a plain 2-port RAM.

## Interface
- WIDTH, 128, data word width in bits
- AW, 5, address width; DEPTH = 2**AW words per bank
- LANES, 8, write-mask lanes; lane width = WIDTH/LANES (must divide exactly)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- we  in  1  write strobe, producer side
- waddr  in  AW  word address within current write bank
- wdata  in  WIDTH  write data
- wmask  in  LANES  lane enable; bit i enables wdata[i*LW +: LW]
- wr_done  in  1  pulse: current write bank complete, hand to reader
- wr_ready  out  1  a bank is free for writing
- wr_bank  out  1  index of current write bank
- rd  in  1  read strobe, consumer side
- raddr  in  AW  word address within current read bank
- rdata  out  WIDTH  read data
- rdata_vld  out  1  rdata carries result of a read issued the previous cycle
- rd_done  in  1  pulse: current read bank consumed, return to writer
- rd_avail  out  1  a filled bank is available for reading
- rd_bank  out  1  index of current read bank
- fill_cnt  out  2  filled banks, 0..2
- err_ovf  out  1  sticky: we or wr_done while wr_ready=0
- err_udf  out  1  sticky: rd or rd_done while rd_avail=0

## Operation
- State: wr_ptr, rd_ptr (1 bit each), cnt (0..2). wr_bank=wr_ptr, rd_bank=rd_ptr, fill_cnt=cnt.
- wr_ready = (cnt!=2); rd_avail = (cnt!=0).
- Write: we && wr_ready writes enabled lanes of bank wr_ptr at waddr; disabled lanes keep old contents. wmask=0 is a legal no-op.
- wr_done && wr_ready: wr_ptr toggles, cnt+1.
- rd_done && rd_avail: rd_ptr toggles, cnt-1.
- Both handshakes accepted in the same cycle: both pointers toggle and cnt is unchanged.
- Read: rd && rd_avail reads bank rd_ptr at raddr.
- rd is ignored while rd_avail=0; rdata_vld stays 0 and rdata holds its value.
- we/wr_done while wr_ready=0 are ignored, and err_ovf is set. rd/rd_done while rd_avail=0 are ignored, and err_udf is set. Both flags clear only on rst.
- Because cnt limits ownership, the writer and reader never address the same bank. There is no read/write collision path.
- we and wr_done in the same cycle: the write lands in the old wr_ptr bank, then the swap happens.
- rd and rd_done in the same cycle: the read uses the old rd_ptr bank, and its data is returned next cycle.
- Storage is not reset. Contents after rst are undefined until rewritten.

## Timing
- Reset values: wr_ready=1, rd_avail=0, wr_bank=0, rd_bank=0, fill_cnt=0, rdata=0, rdata_vld=0, err_ovf=0, err_udf=0.
- Read latency is 1: rd accepted at edge n gives rdata/rdata_vld=1 after edge n+1. rdata_vld is 0 in any cycle following no accepted read.
- rdata holds its last value until the next accepted read.
- Write completes at the edge where we is sampled.
- A word written at edge n is readable by a read accepted at n+1 or later, once the bank has been handed over.
- wr_done at edge n makes rd_avail rise after edge n, so the first read can be accepted at edge n+1.
- rd_done at edge n makes wr_ready rise after edge n when cnt was 2.
- rst asserted mid-operation applies at the next edge. Any in-flight read is dropped: rdata_vld=0, rdata=0. Pointers and cnt return to 0.
- All status outputs are registered or decoded from registers only. There is no input-to-output combinational path.

## Test plan
- Reset then idle: all outputs at reset values; a rd pulse gives rdata_vld=0 and sets err_udf=1.
- Fill bank 0 with waddr k -> wdata=k (k=0..31), wmask=all ones, wr_done: rd_avail=1, rd_bank=0, wr_bank=1. Reads raddr 0..31 return k one cycle later with rdata_vld=1.
- Lane mask: write 0xFF..FF with wmask=8'hFF, then 0x00..00 to the same address with wmask=8'h0F. After handover, read returns upper 64 bits all ones and lower 64 bits zero.
- Two wr_done without rd_done: fill_cnt=2, wr_ready=0. A further we is ignored and sets err_ovf. One rd_done returns fill_cnt=1, wr_ready=1, rd_bank=1.
- Simultaneous wr_done and rd_done at fill_cnt=1: both pointers toggle and fill_cnt stays 1. A same-cycle rd returns data from the old read bank.
- Assert rst one cycle after an accepted rd: rdata_vld=0 and rdata=0 in the next cycle, fill_cnt=0, and both error flags are cleared.
